// File: rtl/register_tree_host_pkg.sv
// Shared types for the register-tree queue host: FSM states, the queue command bundle,
// and the default settle length derived from the tree depth.
package register_tree_host_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Widest key the command bundle can carry; hosts use the low DATA_WIDTH bits.
    localparam int CMD_DATA_MAX = 64;

    typedef struct packed {
        logic                    wrt;
        logic                    read;
        logic [CMD_DATA_MAX-1:0] data;
    } cmd_t;

    // The tree needs one compare-and-swap pair of phases per level to restore order.
    function automatic int settle_default(input int queue_size);
        return 2 * $clog2(queue_size);
    endfunction

endpackage

// File: rtl/pq_settle_timer.sv
// Loadable down-counter timing the quiet period after each queue command.
// Latency: value updates on the edge after load; done is combinational on value.
// Backpressure: none; load always wins over counting down.
module pq_settle_timer #(
    parameter int WIDTH = 2
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             done
);

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - 1'b1;
        end
    end

    assign done = (value == '0);

endmodule

// File: rtl/register_tree_host.sv
// Host controller turning push/pop valid-ready streams into register-tree queue commands.
// Latency: commands are combinational in IDLE; each command is followed by SETTLE_CYCLES busy cycles.
// Backpressure: o_s_ready/o_m_valid drop while settling; ingress stalls on queue full unless a replace is possible.
module register_tree_host
    import register_tree_host_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int QUEUE_SIZE    = 3,
    parameter int SETTLE_CYCLES = settle_default(QUEUE_SIZE),
    parameter bit REPLACE_ENA   = 1'b1
) (
    input  logic                          i_CLK,
    input  logic                          i_RSTn,
    input  logic                          i_s_valid,
    output logic                          o_s_ready,
    input  logic [DATA_WIDTH-1:0]         i_s_data,
    output logic                          o_m_valid,
    input  logic                          i_m_ready,
    output logic [DATA_WIDTH-1:0]         o_m_data,
    output logic                          o_pq_wrt,
    output logic                          o_pq_read,
    output logic [DATA_WIDTH-1:0]         o_pq_data,
    input  logic                          i_pq_full,
    input  logic                          i_pq_empty,
    input  logic [DATA_WIDTH-1:0]         i_pq_top,
    output logic [$clog2(QUEUE_SIZE+1)-1:0] o_count,
    output logic                          o_busy,
    output logic                          o_drop
);

    localparam int CW          = $clog2(QUEUE_SIZE + 1);
    localparam int TW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [CW-1:0] COUNT_MAX = CW'(QUEUE_SIZE);

    state_t          state_q;
    state_t          state_d;
    cmd_t            cmd;
    logic            idle;
    logic            pop;
    logic            accept;
    logic            push;
    logic            zero_key;
    logic            issue;
    logic            timer_load;
    logic            timer_done;
    logic [TW-1:0]   settle_left_unused;
    logic            cmd_data_unused;
    logic [CW-1:0]   count_q;
    logic            drop_q;

    assign idle      = (state_q == IDLE);
    assign o_busy    = (state_q == SETTLE);
    assign o_m_valid = idle && !i_pq_empty;
    assign o_m_data  = o_m_valid ? i_pq_top : '0;
    assign pop       = o_m_valid && i_m_ready;

    // The i_m_ready -> o_s_ready path is deliberate: a pop frees the slot a replace reuses.
    always_comb begin
        if (REPLACE_ENA) begin
            o_s_ready = idle && (!i_pq_full || pop);
        end else begin
            o_s_ready = idle && !i_pq_full && !pop;
        end
    end

    // Key 0 marks an empty slot inside the tree, so it is handshaken but never written.
    assign accept     = i_s_valid && o_s_ready;
    assign push       = accept && (i_s_data != '0);
    assign zero_key   = accept && (i_s_data == '0);
    assign issue      = push || pop;
    assign timer_load = idle && issue && (SETTLE_CYCLES > 0);

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue && (SETTLE_CYCLES > 0)) state_d = SETTLE;
            SETTLE:  if (timer_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd = '0;
        if (idle) begin
            cmd.wrt  = push;
            cmd.read = pop;
            if (push) begin
                cmd.data[DATA_WIDTH-1:0] = i_s_data;
            end
        end
    end

    assign o_pq_wrt        = cmd.wrt;
    assign o_pq_read       = cmd.read;
    assign o_pq_data       = cmd.data[DATA_WIDTH-1:0];
    assign cmd_data_unused = ^cmd.data;

    pq_settle_timer #(
        .WIDTH(TW)
    ) u_settle_timer (
        .i_CLK      (i_CLK),
        .i_RSTn     (i_RSTn),
        .load       (timer_load),
        .load_value (TW'(SETTLE_LOAD)),
        .value      (settle_left_unused),
        .done       (timer_done)
    );

    // Replace leaves occupancy unchanged; saturation guards against a misbehaving queue.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            count_q <= '0;
        end else if (push && !pop && (count_q != COUNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end else if (pop && !push && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= zero_key;
        end
    end

    assign o_count = count_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_register_tree_host.sv
// Drives a replace-enabled and a replace-disabled host from the same streams, each attached to a
// behavioural queue, and compares every output each cycle against a per-instance reference model.
module tb_register_tree_host;

    localparam int DW = 16;
    localparam int QS = 3;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          m_ready;

    logic          s_ready  [2];
    logic          m_valid  [2];
    logic [DW-1:0] m_data   [2];
    logic          pq_wrt   [2];
    logic          pq_read  [2];
    logic [DW-1:0] pq_data  [2];
    logic          pq_full  [2];
    logic          pq_empty [2];
    logic [DW-1:0] pq_top   [2];
    logic [1:0]    count    [2];
    logic          busy     [2];
    logic          drop     [2];

    // qs[0..1]: queue contents seen by each DUT; qs[2..3]: contents the model expects.
    int qs [4][$];
    int busy_left [2];
    bit drop_exp  [2];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_tree_host #(
        .DATA_WIDTH(DW), .QUEUE_SIZE(QS), .SETTLE_CYCLES(SC), .REPLACE_ENA(1'b1)
    ) dut_rep (
        .i_CLK(clk), .i_RSTn(rstn),
        .i_s_valid(s_valid), .o_s_ready(s_ready[0]), .i_s_data(s_data),
        .o_m_valid(m_valid[0]), .i_m_ready(m_ready), .o_m_data(m_data[0]),
        .o_pq_wrt(pq_wrt[0]), .o_pq_read(pq_read[0]), .o_pq_data(pq_data[0]),
        .i_pq_full(pq_full[0]), .i_pq_empty(pq_empty[0]), .i_pq_top(pq_top[0]),
        .o_count(count[0]), .o_busy(busy[0]), .o_drop(drop[0])
    );

    register_tree_host #(
        .DATA_WIDTH(DW), .QUEUE_SIZE(QS), .SETTLE_CYCLES(SC), .REPLACE_ENA(1'b0)
    ) dut_norep (
        .i_CLK(clk), .i_RSTn(rstn),
        .i_s_valid(s_valid), .o_s_ready(s_ready[1]), .i_s_data(s_data),
        .o_m_valid(m_valid[1]), .i_m_ready(m_ready), .o_m_data(m_data[1]),
        .o_pq_wrt(pq_wrt[1]), .o_pq_read(pq_read[1]), .o_pq_data(pq_data[1]),
        .i_pq_full(pq_full[1]), .i_pq_empty(pq_empty[1]), .i_pq_top(pq_top[1]),
        .o_count(count[1]), .o_busy(busy[1]), .o_drop(drop[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int q_max(input int i);
        int m = 0;
        foreach (qs[i][j]) if (qs[i][j] > m) m = qs[i][j];
        return m;
    endfunction

    task automatic q_pop_max(input int i);
        int idx = -1;
        int m = 0;
        foreach (qs[i][j]) if (qs[i][j] > m) begin m = qs[i][j]; idx = j; end
        if (idx >= 0) qs[i].delete(idx);
    endtask

    task automatic env_refresh();
        for (int k = 0; k < 2; k++) begin
            pq_full[k]  = (qs[k].size() >= QS);
            pq_empty[k] = (qs[k].size() == 0);
            pq_top[k]   = DW'(q_max(k));
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) qs[i].delete();
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = 0;
            drop_exp[k]  = 1'b0;
        end
        env_refresh();
    endtask

    task automatic step(input bit v, input int d, input bit mr);
        bit ew [2];
        bit er [2];
        int ed [2];
        @(negedge clk);
        s_valid = v;
        s_data  = DW'(d);
        m_ready = mr;
        #1;
        for (int k = 0; k < 2; k++) begin
            bit idle, mv, pp, full, sr, ps, zr;
            string sfx;
            sfx  = $sformatf("[%0d]", k);
            idle = (busy_left[k] == 0);
            mv   = idle && (qs[k+2].size() != 0);
            pp   = mv && mr;
            full = (qs[k+2].size() == QS);
            sr   = (k == 0) ? (idle && (!full || pp)) : (idle && !full && !pp);
            ps   = v && sr && (d != 0);
            zr   = v && sr && (d == 0);
            chk({"s_ready", sfx}, 32'(s_ready[k]), 32'(sr));
            chk({"m_valid", sfx}, 32'(m_valid[k]), 32'(mv));
            chk({"m_data", sfx},  32'(m_data[k]),  mv ? 32'(q_max(k+2)) : 32'd0);
            chk({"pq_wrt", sfx},  32'(pq_wrt[k]),  32'(ps));
            chk({"pq_read", sfx}, 32'(pq_read[k]), 32'(pp));
            chk({"pq_data", sfx}, 32'(pq_data[k]), ps ? 32'(d) : 32'd0);
            chk({"busy", sfx},    32'(busy[k]),    32'(!idle));
            chk({"drop", sfx},    32'(drop[k]),    32'(drop_exp[k]));
            chk({"count", sfx},   32'(count[k]),   32'(qs[k+2].size()));
            ew[k] = pq_wrt[k];
            er[k] = pq_read[k];
            ed[k] = int'(pq_data[k]);
            if (pp) q_pop_max(k+2);
            if (ps) qs[k+2].push_back(d);
            drop_exp[k] = zr;
            if (ps || pp) busy_left[k] = SC;
            else if (busy_left[k] > 0) busy_left[k]--;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (er[k]) q_pop_max(k);
            if (ew[k] && qs[k].size() < QS) qs[k].push_back(ed[k]);
        end
        env_refresh();
    endtask

    task automatic hold(input int n, input bit v, input int d, input bit mr);
        for (int i = 0; i < n; i++) step(v, d, mr);
    endtask

    initial begin
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_busy[%0d]", k),    32'(busy[k]),    32'd0);
            chk($sformatf("rst_count[%0d]", k),   32'(count[k]),   32'd0);
            chk($sformatf("rst_drop[%0d]", k),    32'(drop[k]),    32'd0);
            chk($sformatf("rst_s_ready[%0d]", k), 32'(s_ready[k]), 32'd1);
            chk($sformatf("rst_m_valid[%0d]", k), 32'(m_valid[k]), 32'd0);
            chk($sformatf("rst_strobe[%0d]", k),  32'({pq_wrt[k], pq_read[k]}), 32'd0);
        end
        rstn = 1'b1;

        // Fill with 5, 9, 3 while egress is stalled, then offer 7 against a full queue.
        hold(3, 1'b0, 0, 1'b0);
        hold(5, 1'b1, 5, 1'b0);
        hold(5, 1'b1, 9, 1'b0);
        hold(5, 1'b1, 3, 1'b0);
        hold(3, 1'b1, 7, 1'b0);
        // Replace on instance 0; pop then delayed push of 7 on instance 1.
        step(1'b1, 7, 1'b1);
        hold(5, 1'b1, 7, 1'b0);
        hold(2, 1'b0, 0, 1'b0);
        hold(30, 1'b0, 0, 1'b1);
        // Zero key is swallowed without a queue command.
        step(1'b1, 0, 1'b0);
        hold(3, 1'b0, 0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0,
                 ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 50)),
                 $urandom_range(0, 1) == 1);
        end

        // Asynchronous reset in the middle of a settle window.
        hold(30, 1'b0, 0, 1'b1);
        step(1'b1, 85, 1'b0);
        hold(2, 1'b0, 0, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_busy[%0d]", k),  32'(busy[k]),  32'd0);
            chk($sformatf("arst_count[%0d]", k), 32'(count[k]), 32'd0);
        end
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_m_valid[%0d]", k), 32'(m_valid[k]), 32'd0);
            chk($sformatf("arst_s_ready[%0d]", k), 32'(s_ready[k]), 32'd1);
        end
        @(negedge clk);
        rstn = 1'b1;
        hold(6, 1'b1, 12, 1'b0);
        hold(12, 1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
